fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_if.sv | 13 +
 rtl/fifo_rd_stream.sv | 116 +++++++++++
 tb/tb_fifo_rd_stream.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Output word stream of the FIFO read-side drain engine: registered valid/ready
// with packet framing on m_last.
interface fifo_rd_stream_if #(
    parameter int FIFO_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops a show-ahead async FIFO into a 2-entry skid
// buffer and re-issues words as a framed valid/ready stream, with pause and flush.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 8,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [FIFO_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  rd_en,
    input  logic                  flush,
    fifo_rd_stream_if.master      m_if,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);
    localparam int                BEAT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic [FIFO_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    entry_t               buf_q [2];
    entry_t               buf_d [2];
    logic                 valid;
    logic                 hs;
    logic                 push;
    logic                 wr_idx;

    // Outputs come only from registers; m_ready never reaches rinc.
    assign valid        = (cnt_q != 2'd0);
    assign hs           = valid & m_if.m_ready;
    assign m_if.m_valid = valid;
    assign m_if.m_data  = buf_q[0].data;
    assign m_if.m_last  = buf_q[0].last;
    assign busy         = (state_q == ST_FLUSH);
    assign word_cnt     = word_cnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        buf_d      = buf_q;
        word_cnt_d = word_cnt_q;
        rinc       = 1'b0;
        push       = 1'b0;
        wr_idx     = cnt_q[0] & ~hs;

        if (hs) begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_RUN: begin
                rinc = rd_en & ~rempty & (cnt_q != 2'd2);
                push = rinc & ~flush;
                if (flush) begin
                    // A word popped in this cycle is dropped along with the buffer.
                    state_d = ST_FLUSH;
                    cnt_d   = 2'd0;
                    beat_d  = '0;
                end else begin
                    if (hs) begin
                        buf_d[0] = buf_q[1];
                    end
                    if (push) begin
                        buf_d[wr_idx] = '{data: rdata, last: (beat_q == BEAT_MAX)};
                        beat_d        = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
                    end
                    cnt_d = cnt_q + 2'(push) - 2'(hs);
                end
            end
            ST_FLUSH: begin
                rinc = ~rempty;
                if (rempty) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (rrst) begin
            rinc = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            beat_q     <= '0;
            word_cnt_q <= '0;
            // NOTE: the skid entries are reset because the head entry drives m_data/m_last directly.
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            word_cnt_q <= word_cnt_d;
            buf_q      <= buf_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural show-ahead FIFO model,
// scoreboard of expected {data,last} words, one task per scenario.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
    localparam int W   = 8;
    localparam int PKT = 16;
    localparam int CW  = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          rclk   = 1'b0;
    logic          rrst   = 1'b1;
    logic          rempty = 1'b1;
    logic [W-1:0]  rdata  = '0;
    logic          rinc;
    logic          rd_en  = 1'b1;
    logic          flush  = 1'b0;
    logic          busy;
    logic [CW-1:0] word_cnt;

    fifo_rd_stream_if #(.FIFO_WIDTH(W)) m_if ();

    fifo_rd_stream #(.FIFO_WIDTH(W), .PKT_LEN(PKT), .CNT_WIDTH(CW)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .rd_en    (rd_en),
        .flush    (flush),
        .m_if     (m_if),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 rclk = ~rclk;

    logic [W-1:0] fifo_q [$];
    exp_t         exp_q  [$];
    exp_t         mon_e;
    int           errors   = 0;
    int           checks   = 0;
    int           pop_cnt  = 0;
    int           cyc      = 0;
    int           hs_first = -1;
    int           hs_last  = -1;
    int           exp_beat = 0;
    logic         flush_at_edge = 1'b0;
    logic         prev_stall    = 1'b0;
    logic [W-1:0] prev_data     = '0;
    logic         prev_last     = 1'b0;

    // FIFO model: pops on rinc, flags/head word change only at the clock edge.
    always @(posedge rclk) begin
        cyc++;
        flush_at_edge <= flush | rrst;
        if (rinc === 1'b1) begin
            checks++;
            if (rempty !== 1'b0 || fifo_q.size() == 0) begin
                errors++;
                $display("FAIL pop_on_empty: rinc=1 with rempty=%b, required no pop at cycle %0d", rempty, cyc);
            end else begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
        rempty <= (fifo_q.size() == 0);
        if (fifo_q.size() != 0) rdata <= fifo_q[0];
    end

    // Output monitor: scoreboard compare on handshakes, stability under stall.
    always @(negedge rclk) begin
        if (rrst === 1'b0) begin
            if (prev_stall && !flush_at_edge) begin
                checks++;
                if (m_if.m_valid !== 1'b1 || m_if.m_data !== prev_data || m_if.m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             m_if.m_valid, m_if.m_data, m_if.m_last, prev_data, prev_last);
                end
            end
            if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h last=%b, required no word", m_if.m_data, m_if.m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_if.m_data !== mon_e.data || m_if.m_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL stream_word: got data=%h last=%b, required data=%h last=%b",
                                 m_if.m_data, m_if.m_last, mon_e.data, mon_e.last);
                    end
                end
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
            end
            prev_stall = (m_if.m_valid === 1'b1) && (m_if.m_ready === 1'b0);
            prev_data  = m_if.m_data;
            prev_last  = m_if.m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic fifo_write(input logic [W-1:0] d, input bit scored);
        exp_t e;
        fifo_q.push_back(d);
        if (scored) begin
            e.data = d;
            e.last = (exp_beat == PKT - 1);
            exp_q.push_back(e);
            exp_beat = (exp_beat == PKT - 1) ? 0 : exp_beat + 1;
        end
    endtask

    task automatic do_reset();
        rrst = 1'b1; rd_en = 1'b1; flush = 1'b0; m_if.m_ready = 1'b0;
        fifo_q.delete(); exp_q.delete(); exp_beat = 0;
        tick(); tick();
        rrst = 1'b0;
        hs_first = -1; hs_last = -1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), limit);
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1; rd_en = 1'b1; flush = 1'b0; m_if.m_ready = 1'b0;
        fifo_q.delete(); exp_q.delete(); exp_beat = 0;
        fifo_write(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b, required 0", rinc); end
        checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", m_if.m_valid); end
        checks++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt: got %0d, required 0", word_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (m_if.m_data !== 8'h00 || m_if.m_last !== 1'b0) begin errors++; $display("FAIL reset_data: got data=%h last=%b, required 00/0", m_if.m_data, m_if.m_last); end
        rrst = 1'b0;
        #1;
        checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL release_rinc: got %b, required 1", rinc); end
        tick();
        checks++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 8'hA5 || m_if.m_last !== 1'b0) begin errors++; $display("FAIL release_word: got valid=%b data=%h last=%b, required 1/a5/0", m_if.m_valid, m_if.m_data, m_if.m_last); end
        m_if.m_ready = 1'b1;
        wait_drain("reset", 5);
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL reset_count: got %0d, required 1", word_cnt); end
    endtask

    task automatic test_streaming();
        int p0;
        do_reset();
        m_if.m_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 32; i++) fifo_write(8'(i), 1'b1);
        tick();
        checks++; if (rinc !== 1'b1 || m_if.m_valid !== 1'b0) begin errors++; $display("FAIL stream_start: got rinc=%b valid=%b, required 1/0", rinc, m_if.m_valid); end
        tick();
        checks++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 8'h00) begin errors++; $display("FAIL stream_latency: got valid=%b data=%h, required 1/00", m_if.m_valid, m_if.m_data); end
        wait_drain("stream", 60);
        checks++; if (hs_last - hs_first !== 31) begin errors++; $display("FAIL stream_rate: got span %0d cycles, required 31", hs_last - hs_first); end
        checks++; if (word_cnt !== 16'd32) begin errors++; $display("FAIL stream_count: got %0d, required 32", word_cnt); end
        checks++; if (pop_cnt - p0 !== 32) begin errors++; $display("FAIL stream_pops: got %0d, required 32", pop_cnt - p0); end
        tick(); tick();
        checks++; if (m_if.m_valid !== 1'b0 || rinc !== 1'b0) begin errors++; $display("FAIL stream_idle: got valid=%b rinc=%b, required 0/0", m_if.m_valid, rinc); end
    endtask

    task automatic test_backpressure();
        int p0;
        do_reset();
        p0 = pop_cnt;
        for (int i = 0; i < 32; i++) fifo_write(8'(i), 1'b1);
        for (int i = 0; i < 12; i++) tick();
        checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL bp_pops: got %0d, required 2", pop_cnt - p0); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b, required 0", rinc); end
        checks++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== 8'h00 || m_if.m_last !== 1'b0) begin errors++; $display("FAIL bp_head: got valid=%b data=%h last=%b, required 1/00/0", m_if.m_valid, m_if.m_data, m_if.m_last); end
        m_if.m_ready = 1'b1;
        wait_drain("bp", 80);
        checks++; if (word_cnt !== 16'd32) begin errors++; $display("FAIL bp_count: got %0d, required 32", word_cnt); end
    endtask

    task automatic test_pause();
        int p0;
        int n = 0;
        do_reset();
        m_if.m_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 32; i++) fifo_write(8'(i), 1'b1);
        while (pop_cnt - p0 < 5 && n < 20) begin
            tick();
            n++;
        end
        rd_en = 1'b0;
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL pause_rinc: got %b, required 0", rinc); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_cnt - p0 !== 5) begin errors++; $display("FAIL pause_pops: got %0d, required 5", pop_cnt - p0); end
        checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL pause_valid: got %b, required 0", m_if.m_valid); end
        checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL pause_count: got %0d, required 5", word_cnt); end
        rd_en = 1'b1;
        wait_drain("pause", 60);
        checks++; if (word_cnt !== 16'd32) begin errors++; $display("FAIL pause_total: got %0d, required 32", word_cnt); end
    endtask

    task automatic test_flush();
        int p0;
        int n = 0;
        do_reset();
        p0 = pop_cnt;
        for (int i = 0; i < 7; i++) fifo_write(8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_cnt - p0 !== 2 || m_if.m_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill: got pops=%0d valid=%b, required 2/1", pop_cnt - p0, m_if.m_valid); end
        flush = 1'b1;
        rd_en = 1'b0;
        tick();
        flush = 1'b0;
        checks++; if (m_if.m_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_enter: got valid=%b busy=%b, required 0/1", m_if.m_valid, busy); end
        p0 = pop_cnt;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_exit: got busy=%b after %0d cycles, required 0", busy, n); end
        checks++; if (pop_cnt - p0 !== 5) begin errors++; $display("FAIL flush_pops: got %0d, required 5", pop_cnt - p0); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL flush_count: got %0d, required 0", word_cnt); end
        rd_en = 1'b1;
        m_if.m_ready = 1'b1;
        exp_beat = 0;
        for (int i = 0; i < 16; i++) fifo_write(8'(8'h80 + i), 1'b1);
        wait_drain("flush", 50);
        checks++; if (word_cnt !== 16'd16) begin errors++; $display("FAIL flush_after_count: got %0d, required 16", word_cnt); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        m_if.m_ready = 1'b1;
        fifo_write(8'h11, 1'b1);
        fifo_write(8'h22, 1'b1);
        wait_drain("rif_pre", 10);
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL rif_pre_count: got %0d, required 2", word_cnt); end
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_write(8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rif_busy: got %b, required 1", busy); end
        rrst = 1'b1;
        rd_en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || m_if.m_valid !== 1'b0) begin errors++; $display("FAIL rif_state: got busy=%b valid=%b, required 0/0", busy, m_if.m_valid); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rif_count: got %0d, required 0", word_cnt); end
        rrst = 1'b0;
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL rif_run_paused: got rinc=%b, required 0", rinc); end
        rd_en = 1'b1;
        #1;
        checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL rif_run_enabled: got rinc=%b, required 1", rinc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_pause();
        test_flush();
        test_reset_in_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
